// File: rtl/aligned_ram_reader.sv
`default_nettype none
// ============================================================================
// Module   : aligned_ram_reader
// Purpose  : Walks the aligned-sequence RAM from entry len-1 down to entry 0
//            and presents the symbols as a ready/valid stream. Traceback
//            writes symbols end-of-alignment first, so this readout order is
//            forward alignment order.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start_i, len_i      - begin readout of len_i symbols
//            rd_addr_o           - RAM address (RAM registers it every edge)
//            ram_data_i          - RAM read data, valid the cycle after addr
//            out_valid_o/out_ready_i/out_data_o/out_last_o - symbol stream
//            busy_o              - high while a readout owns the RAM port
//            done_o              - one-cycle pulse when the readout completes
// Revision : 1.0 - initial release
// ============================================================================
module aligned_ram_reader #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N*N+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [BitAddr:0] len_i,
    output logic [BitAddr:0] rd_addr_o,
    input  logic [2:0]       ram_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [2:0]       out_data_o,
    output logic             out_last_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int             C_DEPTH_I = N * N;
    localparam logic [BitAddr:0] C_DEPTH = C_DEPTH_I[BitAddr:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [BitAddr:0] rd_addr_q, rd_addr_d;
    logic [BitAddr:0] remaining_q, remaining_d;
    logic             inflight_q, inflight_d;
    logic             tag_q, tag_d;

    // Two-entry output FIFO; each entry is {symbol, last}.
    logic [3:0]       fifo_mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q, count_d;

    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    logic [2:0]       w_occ;
    logic [BitAddr:0] w_len_sat;

    always_comb begin
        w_pop     = (count_q != 2'd0) & out_ready_i;
        w_push    = inflight_q;
        // Occupancy the FIFO will have once the beat in flight lands and the
        // current head is (possibly) popped; issue only if a slot stays free.
        w_occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
        w_issue   = (state_q == S_STREAM) && (remaining_q != '0) && (w_occ < 3'd2);
        w_len_sat = (len_i > C_DEPTH) ? C_DEPTH : len_i;
        count_d   = count_q + {1'b0, w_push} - {1'b0, w_pop};
    end

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        inflight_d  = w_issue;
        tag_d       = tag_q;

        if (w_issue) begin
            tag_d = (rd_addr_q == '0);
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (w_len_sat == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        rd_addr_d   = w_len_sat - 1'b1;
                        remaining_d = w_len_sat;
                        state_d     = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (w_issue) begin
                    // Address saturates at 0 after the final entry is read.
                    if (rd_addr_q != '0) begin
                        rd_addr_d = rd_addr_q - 1'b1;
                    end
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == {{BitAddr{1'b0}}, 1'b1}) begin
                        state_d = S_DRAIN;
                    end
                end else if (remaining_q == '0) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight_q && (count_q == 2'd0)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            tag_q       <= 1'b0;
            fifo_mem_q[0] <= 4'd0;
            fifo_mem_q[1] <= 4'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            tag_q       <= tag_d;
            count_q     <= count_d;
            if (w_push) begin
                fifo_mem_q[wr_ptr_q] <= {ram_data_i, tag_q};
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign rd_addr_o   = rd_addr_q;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = fifo_mem_q[rd_ptr_q][3:1];
    assign out_last_o  = fifo_mem_q[rd_ptr_q][0];
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_aligned_ram_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_aligned_ram_reader
// Purpose  : Directed and randomized bench for aligned_ram_reader. A simple
//            registered RAM feeds the reader; the expected stream for each
//            readout is the RAM contents listed from len-1 down to 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aligned_ram_reader;

    localparam int C_N  = 128;
    localparam int C_BA = $clog2(C_N*C_N+1);

    logic            clk;
    logic            rst_n;
    logic            start_i;
    logic [C_BA:0]   len_i;
    logic [C_BA:0]   rd_addr_o;
    logic [2:0]      ram_data_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [2:0]      out_data_o;
    logic            out_last_o;
    logic            busy_o;
    logic            done_o;

    logic [2:0]      ram [0:C_N*C_N-1];

    int checks;
    int failures;

    aligned_ram_reader #(.N(C_N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .len_i       (len_i),
        .rd_addr_o   (rd_addr_o),
        .ram_data_i  (ram_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data for the address present at an edge appears
    // after that edge.
    always @(posedge clk) ram_data_i <= ram[rd_addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One readout: start at a negedge, then observe every negedge (n = cycles
    // after the start edge). rnd selects random backpressure; mid_n > 0 pulses
    // an extra start (len 2) at that cycle, which must be ignored.
    task automatic run_case(input int len, input bit rnd, input int mid_n);
        logic [3:0] expq [$];
        logic [3:0] held;
        logic [3:0] exp_beat;
        bit         stalled;
        int         n, first_n, last_n, done_n, budget;
        for (int i = len - 1; i >= 0; i--) expq.push_back({ram[i], (i == 0)});
        @(negedge clk);
        start_i     = 1'b1;
        len_i       = len[C_BA:0];
        out_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n       = 1;
        first_n = -1;
        last_n  = -1;
        done_n  = -1;
        stalled = 1'b0;
        held    = 4'd0;
        budget  = 40 * len + 40;
        while (n < budget) begin
            if (n == mid_n) begin
                start_i = 1'b1;
                len_i   = 2;
            end else begin
                start_i = 1'b0;
            end
            out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled)
                chk("stall_hold", {28'd0, out_valid_o, out_data_o}, {28'd1, held[3:1]});
            if (len > 0 && busy_o && done_n < 0)
                chk("rd_addr_range", 32'(rd_addr_o <= (len - 1)), 32'd1);
            if (out_valid_o) begin
                if (first_n < 0) first_n = n;
                if (out_ready_i) begin
                    if (expq.size() == 0) begin
                        chk("extra_beat", {28'd0, out_data_o, out_last_o}, 32'hFFFF);
                    end else begin
                        exp_beat = expq.pop_front();
                        chk("beat", {28'd0, out_data_o, out_last_o}, {28'd0, exp_beat});
                    end
                    if (out_last_o) last_n = n;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = {out_data_o, out_last_o};
                end
            end else begin
                stalled = 1'b0;
            end
            if (done_o) begin
                if (done_n >= 0) chk("done_twice", 32'(n), 32'(done_n));
                else begin
                    done_n = n;
                    chk("busy_with_done", {31'd0, busy_o}, 32'd1);
                end
            end else if (done_n >= 0 && n == done_n + 1) begin
                chk("idle_after_done", {30'd0, busy_o, out_valid_o}, 32'd0);
                break;
            end
            @(negedge clk);
            n++;
        end
        start_i     = 1'b0;
        out_ready_i = 1'b1;
        if (done_n < 0) chk("timeout_no_done", 32'(n), 32'(budget + 1));
        chk("beats_left", 32'(expq.size()), 32'd0);
        if (len == 0) begin
            chk("len0_done_latency", 32'(done_n), 32'd1);
            chk("len0_no_beat", 32'(first_n), 32'hFFFF_FFFF);
        end else begin
            chk("first_beat_latency", 32'(first_n), 32'd3);
            chk("done_after_last", 32'(done_n), 32'(last_n + 2));
            if (!rnd) chk("last_beat_cycle", 32'(last_n), 32'(len + 2));
        end
    endtask

    initial begin
        int rl;
        logic [3:0] fixed5 [5];
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        start_i     = 1'b0;
        len_i       = '0;
        out_ready_i = 1'b1;
        for (int i = 0; i < C_N*C_N; i++) ram[i] = 3'($urandom_range(0, 7));

        repeat (3) @(negedge clk);
        chk("reset_state", {rd_addr_o, 9'd0, out_valid_o, out_data_o, out_last_o, busy_o, done_o},
            32'd0);
        rst_n = 1'b1;

        // Fixed pattern: expect beats 0,4,3,2,1 with last on the fifth.
        fixed5 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        for (int i = 0; i < 5; i++) ram[i] = fixed5[i][2:0];
        run_case(5, 1'b0, 0);

        run_case(0, 1'b0, 0);

        ram[0] = 3'd3;
        run_case(1, 1'b0, 0);

        for (int i = 0; i < 16; i++) ram[i] = 3'($urandom_range(0, 7));
        run_case(8, 1'b1, 0);

        // Extra start mid-stream is ignored; a start right after done is taken.
        run_case(6, 1'b0, 4);
        run_case(2, 1'b0, 0);

        for (int k = 0; k < 3; k++) begin
            rl = $urandom_range(2, 20);
            run_case(rl, 1'b1, 5);
        end

        // Asynchronous abort in the middle of a len=10 readout.
        @(negedge clk);
        start_i = 1'b1;
        len_i   = 10;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {rd_addr_o, 9'd0, out_valid_o, out_data_o, out_last_o, busy_o, done_o},
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            repeat (6) begin
                @(negedge clk);
                seen = seen | done_o | out_valid_o | busy_o;
            end
            chk("no_done_after_abort", {31'd0, seen}, 32'd0);
        end
        run_case(3, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
